// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the two-port SRAM arbiter.
//   state_t    : sequencer states (IDLE, SETUP, ACCESS, DONE)
//   mem_req_t  : one latched SRAM command {we, be, addr, wdata}
//   sat_inc()  : saturating increment used by the optional statistics counters
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            be;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Requester-side bundle for the two SRAM ports.
//   pN_req/pN_we/pN_be/pN_addr/pN_wdata : command from requester N
//   pN_rdata/pN_ack                      : read data and completion pulse to N
// Modports:
//   master : requester view (drives commands, receives rdata/ack)
//   slave  : arbiter view
// -----------------------------------------------------------------------------
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              p0_req;
    logic              p0_we;
    logic [1:0]        p0_be;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_ack;

    logic              p1_req;
    logic              p1_we;
    logic [1:0]        p1_be;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_ack;

    modport master (
        output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
        input  p0_rdata, p0_ack,
        output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
        input  p1_rdata, p1_ack
    );

    modport slave (
        input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
        output p0_rdata, p0_ack,
        input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
        output p1_rdata, p1_ack
    );

endinterface

// File: rtl/sram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rr_arbiter
// Two-way round-robin grant selection.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit N = port N)
//   en         : commit the current grant (arbiter is idle and a req is pending)
//   grant      : index of the winning port (combinational)
//   ptr        : index of the port granted most recently
// The pointer resets to 1 so that port 0 wins the first tie.
// -----------------------------------------------------------------------------
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic       grant,
    output logic       ptr
);

    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        grant = ~ptr_reg;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~ptr_reg;   // tie: favour the port not served last
            default: grant = ~ptr_reg;
        endcase
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (en) begin
            ptr_next = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b1;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Two-port arbiter and cycle sequencer for an asynchronous 16-bit SRAM.
// One whole access is granted at a time and walks IDLE -> SETUP ->
// ACCESS (WAIT_STATES+1 cycles) -> DONE -> IDLE.
//
// Ports:
//   Clk            : system clock
//   Reset          : asynchronous active-low reset
//   bus            : requester bundle (sram_arbiter_if.slave), ports 0 and 1
//   CE/UB/LB/OE/WE : SRAM strobes, active-low
//   ADDR           : SRAM word address
//   Data           : SRAM data bus, driven only while a write is in flight
//   busy           : high whenever the sequencer is not IDLE
//   grant          : port owning the current or most recent access
//
// Optional (macro SRAM_ARB_STATS_EN):
//   p0_count, p1_count : saturating per-port ack counters
//   conflict_count     : saturating count of grants made with both reqs high
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     bus,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data,
    output logic              busy,
    output logic              grant
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  p0_count,
    output logic [CNT_W-1:0]  p1_count,
    output logic [CNT_W-1:0]  conflict_count
`endif
);

    state_t     state_reg, state_next;
    logic [2:0] wait_reg, wait_next;
    mem_req_t   cmd_reg, cmd_next;
    logic       grant_reg, grant_next;

    logic [1:0] req_vec;
    logic       arb_en;
    logic       arb_grant;
    logic       arb_ptr_unused;
    mem_req_t   port_cmd [2];
    logic       data_oe;
    logic       last_access;

    logic [DATA_W-1:0] rdata_arr [2];
    logic              ack_arr   [2];

    assign req_vec = {bus.p1_req, bus.p0_req};
    assign arb_en  = (state_reg == IDLE) && (req_vec != 2'b00);

    assign port_cmd[0] = {bus.p0_we, bus.p0_be, bus.p0_addr, bus.p0_wdata};
    assign port_cmd[1] = {bus.p1_we, bus.p1_be, bus.p1_addr, bus.p1_wdata};

    sram_rr_arbiter u_rr (
        .clk   (Clk),
        .rst_n (Reset),
        .req   (req_vec),
        .en    (arb_en),
        .grant (arb_grant),
        .ptr   (arb_ptr_unused)
    );

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        cmd_next   = cmd_reg;
        grant_next = grant_reg;
        case (state_reg)
            IDLE: begin
                if (arb_en) begin
                    grant_next = arb_grant;
                    cmd_next   = port_cmd[arb_grant];
                    state_next = SETUP;
                end
            end
            SETUP: begin
                // Loaded here so ACCESS lasts exactly WAIT_STATES+1 cycles.
                wait_next  = 3'(WAIT_STATES);
                state_next = ACCESS;
            end
            ACCESS: begin
                if (wait_reg == 3'd0) begin
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg - 3'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            wait_reg  <= 3'd0;
            cmd_reg   <= '0;
            grant_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            cmd_reg   <= cmd_next;
            grant_reg <= grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Strobes, decoded from registered state so reset releases the bus
    // immediately. OE and WE are never low together: OE is only pulled
    // low for reads, WE only for writes.
    // ------------------------------------------------------------------
    always_comb begin
        CE      = 1'b1;
        UB      = 1'b1;
        LB      = 1'b1;
        OE      = 1'b1;
        WE      = 1'b1;
        data_oe = 1'b0;
        case (state_reg)
            SETUP: begin
                CE      = 1'b0;
                UB      = ~cmd_reg.be[1];
                LB      = ~cmd_reg.be[0];
                OE      = cmd_reg.we;
                data_oe = cmd_reg.we;
            end
            ACCESS: begin
                CE      = 1'b0;
                UB      = ~cmd_reg.be[1];
                LB      = ~cmd_reg.be[0];
                OE      = cmd_reg.we;
                WE      = ~cmd_reg.we;
                data_oe = cmd_reg.we;
            end
            DONE: begin
                // WE/OE already released; CE, byte lanes and write data
                // stay put one more cycle for hold time.
                CE      = 1'b0;
                UB      = ~cmd_reg.be[1];
                LB      = ~cmd_reg.be[0];
                data_oe = cmd_reg.we;
            end
            default: begin
                CE = 1'b1;
            end
        endcase
    end

    assign ADDR  = cmd_reg.addr;
    assign Data  = data_oe ? cmd_reg.wdata : {DATA_W{1'bz}};
    assign busy  = (state_reg != IDLE);
    assign grant = grant_reg;

    assign last_access = (state_reg == ACCESS) && (wait_reg == 3'd0);

    // ------------------------------------------------------------------
    // Per-port read data, ack and optional ack counters
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;
            logic              mine;

            assign mine = (grant_reg == 1'(gi));

            // Captured on the edge that closes the last ACCESS cycle,
            // while OE is still low and the SRAM is driving Data.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    rdata_reg <= '0;
                end else if (last_access && !cmd_reg.we && mine) begin
                    rdata_reg <= Data;
                end
            end

            assign rdata_arr[gi] = rdata_reg;
            assign ack_arr[gi]   = (state_reg == DONE) && mine;

`ifdef SRAM_ARB_STATS_EN
            logic [CNT_W-1:0] count_reg;

            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    count_reg <= '0;
                end else if (ack_arr[gi]) begin
                    count_reg <= sat_inc(count_reg);
                end
            end
`endif
        end
    endgenerate

    assign bus.p0_rdata = rdata_arr[0];
    assign bus.p1_rdata = rdata_arr[1];
    assign bus.p0_ack   = ack_arr[0];
    assign bus.p1_ack   = ack_arr[1];

`ifdef SRAM_ARB_STATS_EN
    logic [CNT_W-1:0] conflict_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            conflict_reg <= '0;
        end else if (arb_en && (req_vec == 2'b11)) begin
            conflict_reg <= sat_inc(conflict_reg);
        end
    end

    assign p0_count       = g_port[0].count_reg;
    assign p1_count       = g_port[1].count_reg;
    assign conflict_count = conflict_reg;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter with an SRAM behavioural model and an
// expected-access scoreboard. Entries are pushed in the order grants are
// predicted and popped when an ack appears. The optional statistics checks
// are compiled when SRAM_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int WS = 1;
    localparam int AW = 20;
    localparam int DW = 16;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          ce, ub, lb, oe, we;
    logic [AW-1:0] addr;
    wire  [DW-1:0] data;
    logic          busy, grant;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]   p0_count, p1_count, conflict_count;
`endif

    sram_arbiter #(.WAIT_STATES(WS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus),
        .CE    (ce),
        .UB    (ub),
        .LB    (lb),
        .OE    (oe),
        .WE    (we),
        .ADDR  (addr),
        .Data  (data),
        .busy  (busy),
        .grant (grant)
`ifdef SRAM_ARB_STATS_EN
        ,
        .p0_count       (p0_count),
        .p1_count       (p1_count),
        .conflict_count (conflict_count)
`endif
    );

    // ---------------- SRAM model (256 words visible) ----------------
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_rd;
    assign mem_rd = mem[addr[7:0]];
    assign data   = (!ce && !oe && we) ? mem_rd : {DW{1'bz}};

    always @(posedge clk) begin
        if (!ce && !we) begin
            if (!ub) mem[addr[7:0]][15:8] <= data[15:8];
            if (!lb) mem[addr[7:0]][7:0]  <= data[7:0];
        end
    end

    // ---------------- bench state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            win_start = 0;
    int            we_low = 0;
    int            oe_low = 0;
    int            ce_windows = 0;
    logic          ce_prev = 1'b1;
    exp_t          sb [$];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd [2];
    int            exp_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock; all per-cycle protocol checks and scoreboard pops happen here.
    task automatic tick();
        exp_t          e;
        logic [1:0]    ublb_exp;
        logic [DW-1:0] rd;
        @(posedge clk);
        #1;
        cyc++;
        chk("we_oe_both_low", 32'(we | oe), 32'd1);
        chk("ack_overlap", 32'(bus.p0_ack & bus.p1_ack), 32'd0);
        if (ce_prev && !ce) begin
            ce_windows++;
            win_start = cyc;
            we_low = 0;
            oe_low = 0;
            if (sb.size() > 0) begin
                ublb_exp = ~sb[0].be;
                chk("setup_addr", 32'(addr), 32'(sb[0].addr));
                chk("setup_ub_lb", 32'({ub, lb}), 32'(ublb_exp));
            end
        end
        ce_prev = ce;
        if (!ce) begin
            if (!we) we_low++;
            if (!oe) oe_low++;
        end
        if (!we && sb.size() > 0) begin
            chk("write_data", 32'(data), 32'(sb[0].wdata));
        end
        if (bus.p0_ack || bus.p1_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(bus.p1_ack), 32'(e.port));
                chk("grant", 32'(grant), 32'(e.port));
                chk("ce_to_ack", 32'(cyc - win_start), 32'(WS + 2));
                chk("we_low_cycles", 32'(we_low), e.we ? 32'(WS + 1) : 32'd0);
                chk("oe_low_cycles", 32'(oe_low), e.we ? 32'd0 : 32'(WS + 2));
                rd = e.port ? bus.p1_rdata : bus.p0_rdata;
                if (e.we) begin
                    chk("rdata_kept", 32'(rd), 32'(last_rd[e.port]));
                end else begin
                    chk("rdata", 32'(rd), 32'(e.rdata));
                    last_rd[e.port] = e.rdata;
                end
            end
        end
    endtask

    // Predict one access and update the reference memory.
    task automatic push_exp(input logic port, input logic wr, input logic [1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t          e;
        logic [DW-1:0] old;
        old     = ref_mem[a[7:0]];
        e.port  = port;
        e.we    = wr;
        e.be    = be;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = old;
        if (wr) begin
            ref_mem[a[7:0]] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
        end
        exp_cnt[port]++;
        sb.push_back(e);
    endtask

    task automatic drive_port(input logic port, input logic req, input logic wr,
                              input logic [1:0] be, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (port) begin
            bus.p1_we = wr; bus.p1_be = be; bus.p1_addr = a; bus.p1_wdata = wd; bus.p1_req = req;
        end else begin
            bus.p0_we = wr; bus.p0_be = be; bus.p0_addr = a; bus.p0_wdata = wd; bus.p0_req = req;
        end
    endtask

    // Single uncontended access starting from IDLE; ack is expected on the
    // (WS+3)th clock edge after req is raised.
    task automatic do_access(input logic port, input logic wr, input logic [1:0] be,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int   n;
        logic got;
        push_exp(port, wr, be, a, wd);
        drive_port(port, 1'b1, wr, be, a, wd);
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            tick();
            n++;
            got = port ? bus.p1_ack : bus.p0_ack;
        end
        drive_port(port, 1'b0, wr, be, a, wd);
        chk("req_to_ack", 32'(n), 32'(WS + 3));
        tick();
        chk("idle_after_access", 32'(busy), 32'd0);
    endtask

    initial begin
        int a0;
        int a1;
        int n;
        int win0;
        drive_port(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // ---- reset state ----
        #1;
        chk("rst_strobes", 32'({ce, ub, lb, oe, we}), 32'h1f);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({bus.p0_ack, bus.p1_ack}), 32'd0);
        chk("rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // ---- p0 full write, then read back ----
        do_access(1'b0, 1'b1, 2'b11, 20'h00010, 16'hBEEF);
        chk("mem_after_write", 32'(mem[8'h10]), 32'h0000BEEF);
        do_access(1'b0, 1'b0, 2'b11, 20'h00010, 16'h0000);

        // ---- p1 lower-byte write, then read ----
        do_access(1'b1, 1'b1, 2'b01, 20'h00010, 16'h1234);
        chk("mem_byte_write", 32'(mem[8'h10]), 32'h0000BE34);
        do_access(1'b1, 1'b0, 2'b11, 20'h00010, 16'h0000);
        chk("p0_rdata_kept", 32'(bus.p0_rdata), 32'h0000BEEF);

        // ---- no byte enables: cycle runs, nothing written ----
        do_access(1'b1, 1'b1, 2'b00, 20'h00010, 16'h0000);
        chk("mem_be00", 32'(mem[8'h10]), 32'h0000BE34);

        // ---- contention: p1 served last, so grants go 0,1,0,1,0,1 ----
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b1, 2'b11, 20'h00020, 16'hA5A5 ^ 16'(i));
            push_exp(1'b1, 1'b0, 2'b11, 20'h00020, 16'h0000);
        end
        win0 = ce_windows;
        a0 = 0;
        a1 = 0;
        n  = 0;
        drive_port(1'b0, 1'b1, 1'b1, 2'b11, 20'h00020, 16'hA5A5);
        drive_port(1'b1, 1'b1, 1'b0, 2'b11, 20'h00020, 16'h0000);
        while ((a0 < 3 || a1 < 3) && n < 100) begin
            tick();
            n++;
            if (bus.p0_ack) begin
                a0++;
                if (a0 == 3) bus.p0_req = 1'b0;
                else bus.p0_wdata = 16'hA5A5 ^ 16'(a0);
            end
            if (bus.p1_ack) begin
                a1++;
                if (a1 == 3) bus.p1_req = 1'b0;
            end
        end
        chk("contention_p0_acks", 32'(a0), 32'd3);
        chk("contention_p1_acks", 32'(a1), 32'd3);
        tick();
        chk("contention_ce_windows", 32'(ce_windows - win0), 32'd6);
        chk("contention_sb_empty", 32'(sb.size()), 32'd0);

`ifdef SRAM_ARB_STATS_EN
        chk("stat_p0_count", 32'(p0_count), 32'(exp_cnt[0]));
        chk("stat_p1_count", 32'(p1_count), 32'(exp_cnt[1]));
        chk("stat_conflict_ge3", 32'(conflict_count >= 16'd3), 32'd1);
`endif

        // ---- reset during the ACCESS phase of a write ----
        drive_port(1'b0, 1'b1, 1'b1, 2'b11, 20'h00030, 16'h7777);
        tick();
        tick();
        chk("pre_reset_in_access", 32'(we), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({ce, ub, lb, oe, we}), 32'h1f);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_acks", 32'({bus.p0_ack, bus.p1_ack}), 32'd0);
        drive_port(1'b0, 1'b0, 1'b1, 2'b11, 20'h00030, 16'h7777);
        last_rd[0] = '0;
        last_rd[1] = '0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_reset_p0_rdata", 32'(bus.p0_rdata), 32'd0);
        do_access(1'b1, 1'b0, 2'b11, 20'h00010, 16'h0000);

`ifdef SRAM_ARB_STATS_EN
        chk("stat_after_reset_p1", 32'(p1_count), 32'(exp_cnt[1]));
        dut.g_port[0].count_reg = 16'hFFFE;
        do_access(1'b0, 1'b0, 2'b11, 20'h00010, 16'h0000);
        chk("stat_reach_max", 32'(p0_count), 32'h0000FFFF);
        do_access(1'b0, 1'b0, 2'b11, 20'h00010, 16'h0000);
        chk("stat_saturate", 32'(p0_count), 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and cycle sequencer for the board's single asynchronous 16-bit SRAM (CE/UB/LB/OE/WE/ADDR/Data).
- Port 0 serves the SLC-3 memory interface (MAR/MDR path via MIO_EN).
- Port 1 serves a secondary master (debug loader / display scanner).
- Grants one whole SRAM access at a time, sequences the active-low strobes with configurable wait states, and owns the Data tri-state.

Parameters:
- WAIT_STATES, 1, extra ACCESS cycles beyond the first (0..7); total ACCESS length = WAIT_STATES+1.
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- p0_req  input  1  port 0 request; held high, with command stable, until p0_ack.
- p0_we  input  1  port 0: 1 = write, 0 = read.
- p0_be  input  2  port 0 byte enables, active-high; [1] = upper byte, [0] = lower byte.
- p0_addr  input  ADDR_W  port 0 word address.
- p0_wdata  input  DATA_W  port 0 write data.
- p0_rdata  output  DATA_W  port 0 read data; valid while p0_ack is high.
- p0_ack  output  1  one-cycle completion pulse for port 0.
- p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_rdata, p1_ack: same as port 0, for port 1.
- CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low.
- ADDR  output  ADDR_W  SRAM address.
- Data  inout  DATA_W  SRAM data bus; driven only during writes.
- busy  output  1  high in every state except IDLE.
- grant  output  1  index of the port owning the current or most recent access.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, DONE.
- Reset asserted (asynchronous):
  - state = IDLE.
  - CE, UB, LB, OE, WE = 1.
  - ADDR = 0; Data = high-Z.
  - p0_ack, p1_ack = 0; p0_rdata, p1_rdata = 0; busy = 0.
  - grant = 0; last-grant pointer = 1, so port 0 wins the first tie.
- IDLE:
  - No req pending: stay in IDLE, all strobes high.
  - Exactly one req: grant that port.
  - Both req: grant the port not granted last (round-robin).
  - On grant, latch the granted port's we/be/addr/wdata into internal registers, then go to SETUP.
- SETUP (1 cycle):
  - ADDR = latched address; CE = 0.
  - UB = ~be[1], LB = ~be[0].
  - Read: OE = 0. Write: OE = 1 and Data driven with wdata.
  - WE stays high.
- ACCESS (WAIT_STATES+1 cycles, down-counter):
  - Write: WE = 0 for all ACCESS cycles.
  - Read: OE = 0; Data sampled into the granted port's rdata register at the end of the last ACCESS cycle.
- DONE (1 cycle):
  - WE = 1 and OE = 1, but CE, ADDR and the write Data drive are held for hold time.
  - Granted port's ack = 1.
  - Next state = IDLE.
  - Leaving DONE: CE = 1, Data = high-Z.
- Latency: request sampled at edge k gives ack high during cycle k+3+WAIT_STATES. Minimum issue interval is WAIT_STATES+4 cycles.
- Requester drops req at or after its ack cycle. A req still high in the IDLE cycle after ack is a new request.
- rdata holds its last value until the next read on that port. Write accesses leave rdata unchanged.
- be = 2'b00: full cycle still runs with UB = LB = 1 (no byte touched); ack is still issued.
- The ungranted port's req is ignored until IDLE. Its ack stays 0 and its rdata is unchanged.
- Reset mid-access: transaction aborted, no ack issued, bus released in the same instant.
- Never: WE = 0 and OE = 0 simultaneously; Data driven while OE = 0.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs p0_count and p1_count (16 bits each).
  - Each counts acks on its port, saturating at 16'hFFFF.
  - Cleared by Reset.
  - Adds output conflict_count (16 bits, saturating): increments on each IDLE grant where both req were high.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS, DONE).
  - ADDR_W and DATA_W defaults.
  - Packed struct mem_req_t {we, be, addr, wdata}.
- Sub-module sram_rr_arbiter:
  - Inputs: 2-bit req vector, enable.
  - Output: grant index plus pointer register.
  - Updates the pointer only when enable is high (IDLE with a req pending).

Test Plan:
- WAIT_STATES = 1; p0 write addr 20'h00010, data 16'hBEEF, be = 2'b11 -> WE low exactly 2 cycles, OE high throughout, p0_ack during cycle k+4; test memory holds 16'hBEEF at 20'h00010.
- p0 read addr 20'h00010 -> OE low in SETUP+ACCESS, p0_rdata = 16'hBEEF while p0_ack = 1, Data never driven by the block.
- p1 write be = 2'b01 with data 16'h1234 onto 16'hBEEF -> UB = 1, LB = 0; subsequent read returns 16'hBE34.
- p0 and p1 req held high continuously -> grants alternate 0,1,0,1; each ack a single-cycle pulse; no overlap of CE-low windows across accesses.
- Reset pulled low during the ACCESS cycle of a write -> all strobes high and Data high-Z immediately, no ack; after release, the next p1-only request completes normally.
- SRAM_ARB_STATS_EN defined, 3 contended rounds -> p0_count = 3, p1_count = 3, conflict_count >= 3; a saturation check preloads the counter near 16'hFFFF and confirms it holds at 16'hFFFF.
